// File: rtl/rr_mux_nto1_reg.sv
// N-input registered multiplexer with valid/ready handshake and round-robin arbitration.
// Define MUX_FIXED_PRIO_EN to replace round-robin with fixed priority (channel 0 highest).
module rr_mux_nto1_reg #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N*WIDTH-1:0] in_data_i,
  input  logic [N-1:0]       in_valid_i,
  output logic [N-1:0]       in_ready_o,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [IDX_W-1:0]   out_src_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0] out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;

  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic             load_en;
  logic             transfer;
  int               cand;

`ifndef MUX_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // Search starts at the round-robin pointer and wraps explicitly, so N need not be 2^k.
  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < N; i++) begin
`ifdef MUX_FIXED_PRIO_EN
      cand = i;
`else
      cand = int'(rr_ptr_q) + i;
      if (cand >= N) cand = cand - N;
`endif
      if (!grant_found && in_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  assign load_en  = ~out_valid_q | out_ready_i;
  assign transfer = grant_found & load_en;

  always_comb begin
    in_ready_o = '0;
    if (transfer) in_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q & ~out_ready_i;
    if (transfer) begin
      out_data_d  = in_data_i[int'(grant_idx)*WIDTH +: WIDTH];
      out_src_d   = grant_idx;
      out_valid_d = 1'b1;
    end
  end

`ifndef MUX_FIXED_PRIO_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer) rr_ptr_d = (grant_idx == IDX_W'(N-1)) ? '0 : grant_idx + IDX_W'(1);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
`ifndef MUX_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
`ifndef MUX_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_rr_mux_nto1_reg.sv
// Self-checking bench for rr_mux_nto1_reg: an N=4/WIDTH=32 instance and an N=3/WIDTH=8
// instance, each tracked by a distance-based arbitration model.
module tb_rr_mux_nto1_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] in_data4;
  logic [3:0]   in_valid4, in_ready4;
  logic [31:0]  out_data4;
  logic [1:0]   out_src4;
  logic         out_valid4, out_ready4;

  logic [23:0]  in_data3;
  logic [2:0]   in_valid3, in_ready3;
  logic [7:0]   out_data3;
  logic [1:0]   out_src3;
  logic         out_valid3, out_ready3;

  rr_mux_nto1_reg #(.WIDTH(32), .N(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst),
    .in_data_i(in_data4), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .out_data_o(out_data4), .out_src_o(out_src4), .out_valid_o(out_valid4),
    .out_ready_i(out_ready4)
  );

  rr_mux_nto1_reg #(.WIDTH(8), .N(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .in_data_i(in_data3), .in_valid_i(in_valid3), .in_ready_o(in_ready3),
    .out_data_o(out_data3), .out_src_o(out_src3), .out_valid_o(out_valid3),
    .out_ready_i(out_ready3)
  );

  int total = 0;
  int bad   = 0;

  // Reference state per instance
  bit          m4_valid, m3_valid;
  logic [31:0] m4_data,  p4_data;
  logic [7:0]  m3_data,  p3_data;
  int          m4_src, m4_ptr, g4;
  int          m3_src, m3_ptr, g3;
  logic [3:0]  exp_ready4;
  logic [2:0]  exp_ready3;

  // Winner is the valid channel closest to the pointer going upward (modulo n).
  function automatic int model_grant(input logic [3:0] v, input int ptr, input int n);
    int best, bestd, d;
    best  = -1;
    bestd = n;
    for (int k = 0; k < n; k++) begin
      if (v[k]) begin
`ifdef MUX_FIXED_PRIO_EN
        d = k;
`else
        d = (k - ptr + n) % n;
`endif
        if (d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m4_valid = 0; m4_data = '0; m4_src = 0; m4_ptr = 0;
    m3_valid = 0; m3_data = '0; m3_src = 0; m3_ptr = 0;
  endtask

  task automatic predict();
    g4 = model_grant(in_valid4, m4_ptr, 4);
    exp_ready4 = '0;
    p4_data = '0;
    if (g4 >= 0 && (!m4_valid || out_ready4)) begin
      exp_ready4[g4] = 1'b1;
      p4_data = in_data4[g4*32 +: 32];
    end
    g3 = model_grant({1'b0, in_valid3}, m3_ptr, 3);
    exp_ready3 = '0;
    p3_data = '0;
    if (g3 >= 0 && (!m3_valid || out_ready3)) begin
      exp_ready3[g3] = 1'b1;
      p3_data = in_data3[g3*8 +: 8];
    end
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    #1;
    if (exp_ready4 != 0) begin
      m4_valid = 1; m4_data = p4_data; m4_src = g4; m4_ptr = (g4 + 1) % 4;
    end else if (m4_valid && out_ready4) begin
      m4_valid = 0;
    end
    if (exp_ready3 != 0) begin
      m3_valid = 1; m3_data = p3_data; m3_src = g3; m3_ptr = (g3 + 1) % 3;
    end else if (m3_valid && out_ready3) begin
      m3_valid = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid4 = '0; in_data4 = '0; out_ready4 = 1'b0;
    in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b0;
    model_reset();
    #3;
    total++;
    if ({out_valid4, out_src4, out_data4} !== '0) begin
      bad++;
      $display("FAIL reset_initial4: got v=%0b src=%0d data=%h, want all zero", out_valid4, out_src4, out_data4);
    end
    total++;
    if ({out_valid3, out_src3, out_data3} !== '0) begin
      bad++;
      $display("FAIL reset_initial3: got v=%0b src=%0d data=%h, want all zero", out_valid3, out_src3, out_data3);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Load a word from ch1, then stall so it is held when reset hits mid-cycle
    in_valid4 = 4'b0010;
    in_data4  = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_valid4 = 4'b1111;
    tick();
    total++;
    if (out_valid4 !== 1'b1 || out_src4 !== 2'd1) begin
      bad++;
      $display("FAIL reset_held_word: got v=%0b src=%0d, want v=1 src=1", out_valid4, out_src4);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if ({out_valid4, out_src4, out_data4} !== '0) begin
      bad++;
      $display("FAIL reset_async: got v=%0b src=%0d data=%h, want all zero", out_valid4, out_src4, out_data4);
    end
    #2;
    rst = 1'b0;
    out_ready4 = 1'b1;
    predict();
    #1;
    total++;
    if (in_ready4 !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_grant: got in_ready=%b, want 0001", in_ready4);
    end
    tick();
    total++;
    if (out_src4 !== 2'd0 || out_valid4 !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_src: got src=%0d v=%0b, want src=0 v=1", out_src4, out_valid4);
    end
  endtask

  task automatic test_single_source();
    in_valid4 = 4'b0100;
    in_data4  = {$urandom, 32'hA5A5_0002, $urandom, $urandom};
    out_ready4 = 1'b1;
    predict();
    #1;
    total++;
    if (in_ready4 !== 4'b0100) begin
      bad++;
      $display("FAIL single_ready: got %b, want 0100", in_ready4);
    end
    tick();
    total++;
    if (out_data4 !== 32'hA5A5_0002 || out_src4 !== 2'd2 || out_valid4 !== 1'b1) begin
      bad++;
      $display("FAIL single_out: got data=%h src=%0d v=%0b, want data=a5a50002 src=2 v=1",
               out_data4, out_src4, out_valid4);
    end
  endtask

  task automatic test_round_robin();
    in_valid4 = 4'b1111;
    out_ready4 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_data4 = {$urandom, $urandom, $urandom, $urandom};
      predict();
      #1;
      total++;
      if (in_ready4 !== exp_ready4) begin
        bad++;
        $display("FAIL rr_ready[%0d]: got %b, want %b", c, in_ready4, exp_ready4);
      end
      tick();
      total++;
      if (out_valid4 !== 1'b1 || out_src4 !== 2'(m4_src) || out_data4 !== m4_data) begin
        bad++;
        $display("FAIL rr_out[%0d]: got v=%0b src=%0d data=%h, want v=1 src=%0d data=%h",
                 c, out_valid4, out_src4, out_data4, m4_src, m4_data);
      end
    end
  endtask

  task automatic test_backpressure();
    in_valid4 = 4'b1111;
    out_ready4 = 1'b1;
    in_data4 = {$urandom, $urandom, $urandom, $urandom};
    tick();
    out_ready4 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_data4 = {$urandom, $urandom, $urandom, $urandom};
      predict();
      #1;
      total++;
      if (in_ready4 !== 4'b0000) begin
        bad++;
        $display("FAIL bp_ready[%0d]: got %b, want 0000", c, in_ready4);
      end
      tick();
      total++;
      if (out_valid4 !== 1'b1 || out_src4 !== 2'(m4_src) || out_data4 !== m4_data) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%0b src=%0d data=%h, want v=1 src=%0d data=%h",
                 c, out_valid4, out_src4, out_data4, m4_src, m4_data);
      end
    end
    out_ready4 = 1'b1;
    predict();
    #1;
    total++;
    if (in_ready4 !== exp_ready4) begin
      bad++;
      $display("FAIL bp_release_ready: got %b, want %b", in_ready4, exp_ready4);
    end
    tick();
    total++;
    if (out_src4 !== 2'(m4_src) || out_data4 !== m4_data) begin
      bad++;
      $display("FAIL bp_release_out: got src=%0d data=%h, want src=%0d data=%h",
               out_src4, out_data4, m4_src, m4_data);
    end
  endtask

  task automatic test_random4();
    for (int c = 0; c < 200; c++) begin
      in_valid4  = 4'($urandom);
      in_data4   = {$urandom, $urandom, $urandom, $urandom};
      out_ready4 = ($urandom_range(0, 3) != 0);
      predict();
      #1;
      total++;
      if (in_ready4 !== exp_ready4) begin
        bad++;
        $display("FAIL rand4_ready[%0d]: got %b, want %b", c, in_ready4, exp_ready4);
      end
      tick();
      total++;
      if (out_valid4 !== m4_valid || out_src4 !== 2'(m4_src) || out_data4 !== m4_data) begin
        bad++;
        $display("FAIL rand4_out[%0d]: got v=%0b src=%0d data=%h, want v=%0b src=%0d data=%h",
                 c, out_valid4, out_src4, out_data4, m4_valid, m4_src, m4_data);
      end
    end
    in_valid4 = '0;
  endtask

  task automatic test_wrap_n3();
    in_valid3  = 3'b100;
    in_data3   = 24'($urandom);
    out_ready3 = 1'b1;
    tick();
    total++;
    if (out_src3 !== 2'd2 || out_valid3 !== 1'b1) begin
      bad++;
      $display("FAIL wrap_ch2: got src=%0d v=%0b, want src=2 v=1", out_src3, out_valid3);
    end
    in_valid3 = 3'b101;
    in_data3  = 24'($urandom);
    predict();
    #1;
    total++;
    if (in_ready3 !== 3'b001) begin
      bad++;
      $display("FAIL wrap_ready: got %b, want 001", in_ready3);
    end
    tick();
    total++;
    if (out_src3 !== 2'd0 || out_data3 !== m3_data) begin
      bad++;
      $display("FAIL wrap_out: got src=%0d data=%h, want src=0 data=%h", out_src3, out_data3, m3_data);
    end
    for (int c = 0; c < 80; c++) begin
      in_valid3  = 3'($urandom);
      in_data3   = 24'($urandom);
      out_ready3 = ($urandom_range(0, 3) != 0);
      predict();
      #1;
      total++;
      if (in_ready3 !== exp_ready3) begin
        bad++;
        $display("FAIL rand3_ready[%0d]: got %b, want %b", c, in_ready3, exp_ready3);
      end
      tick();
      total++;
      if (out_src3 > 2'd2 || out_valid3 !== m3_valid || out_src3 !== 2'(m3_src) || out_data3 !== m3_data) begin
        bad++;
        $display("FAIL rand3_out[%0d]: got v=%0b src=%0d data=%h, want v=%0b src=%0d data=%h",
                 c, out_valid3, out_src3, out_data3, m3_valid, m3_src, m3_data);
      end
    end
    in_valid3 = '0;
  endtask

`ifdef MUX_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    in_valid4  = 4'b1111;
    out_ready4 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_data4 = {$urandom, $urandom, $urandom, $urandom};
      tick();
      total++;
      if (out_src4 !== 2'd0) begin
        bad++;
        $display("FAIL fixed_all[%0d]: got src=%0d, want 0", c, out_src4);
      end
    end
    in_valid4 = 4'b1110;
    tick();
    total++;
    if (out_src4 !== 2'd1) begin
      bad++;
      $display("FAIL fixed_drop0: got src=%0d, want 1", out_src4);
    end
    in_valid4 = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_wrap_n3();
`ifdef MUX_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
